ps_pl_axil_reg_slave: RTL and testbench

AXI4-Lite responder (slave) register file in the PL. It terminates the PS-side AXI4-Lite master that writes and reads the control words. It holds NUM_REGS 32-bit read/write registers, drives them to PL logic, and emits a one-cycle pulse per register on each completed write. This is the target end of the PS→PL control path.

---
 rtl/ps_pl_axil_reg_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_ps_pl_axil_reg_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps_pl_axil_reg_slave.sv
// AXI4-Lite slave register file for the PS->PL control path: NUM_REGS read/write
// words exported to PL logic, with a one-cycle pulse per completed register write.
//
// state     | meaning
// W_IDLE    | ready for AW and W; commit directly if both arrive together
// W_WAIT_AW | W captured, waiting for the address
// W_WAIT_W  | AW captured, waiting for the data
// W_RESP    | write done, holding BVALID/BRESP until BREADY
// R_IDLE    | ready for AR
// R_RESP    | holding RVALID/RDATA/RRESP until RREADY
module ps_pl_axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0]                reg_wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NB    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_RESP} r_state_t;

    w_state_t              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic [DW-1:0]         regs_q [NUM_REGS];
    logic [DW-1:0]         regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;

    r_state_t              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DW-1:0]         rdata_q, rdata_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit;
    logic                  c_in_range;
    logic [IDX_W-1:0]      c_idx;
    logic [DW-1:0]         c_data;
    logic [NB-1:0]         c_strb;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_in_range;
    logic [DW-1:0]         r_word;

    logic                  unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;

    always_comb begin
        w_state_d  = w_state_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        regs_d     = regs_q;
        pulse_d    = '0;
        commit     = 1'b0;
        c_idx      = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        c_data     = S_AXI_WDATA;
        c_strb     = S_AXI_WSTRB;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    w_state_d = W_WAIT_W;
                end else if (w_hs) begin
                    wdata_d   = S_AXI_WDATA;
                    wstrb_d   = S_AXI_WSTRB;
                    w_state_d = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                c_idx = aw_idx_q;
                if (w_hs) commit = 1'b1;
            end
            W_WAIT_AW: begin
                c_data = wdata_q;
                c_strb = wstrb_q;
                if (aw_hs) commit = 1'b1;
            end
            default: begin
                if (bvalid_q && S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
        endcase
        c_in_range = (32'(c_idx) < 32'(NUM_REGS));
        if (commit) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = c_in_range ? RESP_OKAY : RESP_SLVERR;
            // The pulse fires even for an all-zero strobe; only out-of-range is silent.
            if (c_in_range) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (c_idx == IDX_W'(k)) begin
                        pulse_d[k] = 1'b1;
                        for (int b = 0; b < NB; b++) begin
                            if (c_strb[b]) regs_d[k][8*b +: 8] = c_data[8*b +: 8];
                        end
                    end
                end
            end
        end
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_AW);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_W);
    end

    // Read data comes from regs_q, i.e. the value before any same-edge commit.
    always_comb begin
        r_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        r_in_range = (32'(r_idx) < 32'(NUM_REGS));
        r_word     = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_idx == IDX_W'(k)) r_word = regs_q[k];
        end
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_in_range ? r_word : '0;
                    rresp_d   = r_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            default: begin
                if (rvalid_q && S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            pulse_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            pulse_q   <= pulse_d;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_wr_pulse  = pulse_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out[DW*k +: DW] = regs_q[k];
    end

endmodule

// File: tb/tb_ps_pl_axil_reg_slave.sv
// Bench for ps_pl_axil_reg_slave: directed scenarios plus random AXI4-Lite traffic
// checked against a word-array model of the register file.
module tb_ps_pl_axil_reg_slave;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          areset;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [127:0]  reg_out;
    logic [3:0]    reg_wr_pulse;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [31:0]   mdl [4];
    logic [31:0]   last_rdata;

    always #5 clk = ~clk;

    ps_pl_axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(4)
    ) dut (
        .ACLK(clk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] mdl_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    // Drive one write with independent AW/W start delays and a BREADY delay.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int         idx;
        bit         ok, aw_done, w_done, aw_hs, w_hs;
        int         cyc;
        logic [3:0] ep;
        idx = int'(addr[AW-1:2]);
        ok = (idx < 4);
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 30) begin
            if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
            if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            if (aw_done && !w_done) check_val("aw_blocked", {awready, wready}, 2'b01);
            if (w_done && !aw_done) check_val("w_blocked", {awready, wready}, 2'b10);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; wvalid = 1'b0; end
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            check_val("wr_timeout", 0, 1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        ep = 4'b0000;
        if (ok) begin
            for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            ep = 4'(1 << idx);
        end
        check_val("bvalid", bvalid, 1);
        check_val("bresp", bresp, ok ? 2'b00 : 2'b10);
        check_val("wr_pulse", reg_wr_pulse, ep);
        check_val("reg_out", reg_out, mdl_flat());
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            check_val("bvalid_hold", {bvalid, bresp}, {1'b1, ok ? 2'b00 : 2'b10});
            check_val("resp_ready", {awready, wready}, 2'b00);
            check_val("pulse_once", reg_wr_pulse, 0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check_val("bvalid_clr", bvalid, 0);
        check_val("aw_ready_back", {awready, wready}, 2'b11);
        check_val("pulse_end", reg_wr_pulse, 0);
    endtask

    // Expected data is taken at #2 so a commit that landed on the previous edge
    // (whose model update happens at #1) is already visible.
    task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly);
        int          idx, cyc;
        bit          ok, done, ar_hs;
        logic [31:0] exp;
        idx = int'(addr[AW-1:2]);
        ok = (idx < 4);
        done = 0; cyc = 0; exp = '0;
        while (!done && cyc < 30) begin
            if (cyc >= ar_dly) begin arvalid = 1'b1; araddr = addr; end
            #1;
            ar_hs = arvalid && arready;
            if (ar_hs) exp = ok ? mdl[idx] : 32'h0;
            @(posedge clk); #1;
            if (ar_hs) begin done = 1; arvalid = 1'b0; end
            cyc++;
        end
        if (!done) begin
            check_val("rd_timeout", 0, 1);
            arvalid = 1'b0;
            return;
        end
        last_rdata = rdata;
        check_val("rvalid", rvalid, 1);
        check_val("rdata", rdata, exp);
        check_val("rresp", rresp, ok ? 2'b00 : 2'b10);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            check_val("r_hold", {rvalid, rresp, rdata}, {1'b1, ok ? 2'b00 : 2'b10, exp});
            check_val("ar_blocked", arready, 0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check_val("rvalid_clr", rvalid, 0);
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        for (int k = 0; k < 4; k++) mdl[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ctrl", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
        check_val("rst_data", {rdata, reg_wr_pulse}, 0);
        check_val("rst_regs", reg_out, 0);
        areset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) axi_write(5'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
        check_val("reg_out_1234", reg_out, 128'h00000004_00000003_00000002_00000001);
        for (int k = 0; k < 4; k++) axi_read(5'(4 * k), 0, 0);

        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(5'h00, 32'h1234_5678, 4'b0101, 0, 0, 0);
        check_val("strb_merge", reg_out[31:0], 32'hFF34_FF78);
        axi_read(5'h00, 0, 2);

        axi_write(5'h08, 32'hA5A5_A5A5, 4'hF, 0, 3, 0);
        axi_read(5'h08, 0, 0);
        axi_write(5'h0C, 32'h5A5A_5A5A, 4'hF, 3, 0, 0);
        axi_read(5'h0D, 1, 0);

        axi_write(5'h04, 32'h0000_0002, 4'hF, 0, 0, 5);

        axi_write(5'h10, 32'h0000_DEAD, 4'hF, 0, 0, 0);
        axi_read(5'h10, 0, 0);
        check_val("oor_rdata", last_rdata, 0);
        axi_write(5'h08, 32'hFFFF_FFFF, 4'h0, 1, 0, 0);

        fork
            axi_write(5'h04, 32'h0000_0009, 4'hF, 0, 0, 0);
            axi_read(5'h04, 0, 0);
        join
        check_val("same_cycle_old", last_rdata, 32'h2);
        axi_read(5'h04, 0, 0);
        check_val("same_cycle_new", last_rdata, 32'h9);

        for (int it = 0; it < 60; it++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 0)
                axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else if (op == 1)
                axi_read(5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                fork
                    axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                    axi_read(5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                join
        end

        axi_write(5'h04, 32'h0000_0009, 4'hF, 0, 0, 0);
        awaddr = 5'h04; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check_val("in_wait_w", {awready, wready}, 2'b01);
        areset = 1'b1;
        @(posedge clk); #1;
        check_val("mid_rst_ctrl", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
        check_val("mid_rst_data", {rdata, reg_wr_pulse}, 0);
        check_val("mid_rst_regs", reg_out, 0);
        areset = 1'b0;
        for (int k = 0; k < 4; k++) mdl[k] = '0;
        wvalid = 1'b1; wdata = 32'h1111_1111; wstrb = 4'hF;
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("no_stale_b", bvalid, 0);
        end
        axi_read(5'h04, 0, 0);
        check_val("rst_reg1", last_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
